// File: rtl/soc_run_ctrl.sv
// Run/dump controller: holds the core in reset, runs it until a halt store or timeout, then streams a data-memory window out.
// Optional store counter built when SOC_RUN_CTRL_STORE_COUNT_EN is defined.
module soc_run_ctrl #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned RESET_CYCLES = 3,
  parameter int unsigned MAX_CYCLES   = 1000,
  parameter logic [ADDR_W-1:0] HALT_ADDR = ADDR_W'(32'h0000_0FFC),
  parameter logic [ADDR_W-1:0] DUMP_BASE = ADDR_W'(0),
  parameter int unsigned DUMP_WORDS   = 1024
) (
  input  logic              clk,
  input  logic              rst,
  output logic              core_rst_o,
  input  logic              data_ce_i,
  input  logic              data_we_i,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic [DATA_W-1:0] data_wdata_i,
  output logic              mem_sel_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              dump_valid_o,
  input  logic              dump_ready_i,
  output logic [DATA_W-1:0] dump_data_o,
  output logic [15:0]       dump_index_o,
  output logic              done_o,
  output logic              timeout_o,
  output logic [DATA_W-1:0] exit_code_o,
  output logic [31:0]       cycle_count_o,
  output logic [31:0]       store_count_o
);

  localparam int unsigned HOLD_W   = $clog2(RESET_CYCLES + 1);
  localparam logic [31:0] MAX_C    = 32'(MAX_CYCLES);
  localparam logic [15:0] LAST_IDX = 16'(DUMP_WORDS - 1);

  typedef enum logic [1:0] {S_HOLD, S_RUN, S_DUMP, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [15:0]         idx_q, idx_d;
  logic                last_loaded_q, last_loaded_d;
  logic                core_rst_d, mem_sel_d, dump_valid_d, done_d, timeout_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic [DATA_W-1:0]   dump_data_d, exit_code_d;
  logic [15:0]         dump_index_d;
  logic [31:0]         cycle_count_d;

  logic        halt_c, hold_done_c, timeout_hit_c, load_c, last_hs_c;
  logic [31:0] cyc_inc_c;

  assign halt_c        = data_ce_i & data_we_i & (data_addr_i == HALT_ADDR);
  assign hold_done_c   = (hold_cnt_q == HOLD_W'(RESET_CYCLES - 1));
  assign cyc_inc_c     = cycle_count_o + 32'd1;
  assign timeout_hit_c = (cyc_inc_c == MAX_C);
  assign load_c        = (~dump_valid_o | dump_ready_i) & ~last_loaded_q;
  assign last_hs_c     = dump_valid_o & dump_ready_i & last_loaded_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_HOLD;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HOLD: if (hold_done_c)             state_d = S_RUN;
      S_RUN:  if (halt_c || timeout_hit_c) state_d = S_DUMP;
      S_DUMP: if (last_hs_c)               state_d = S_DONE;
      default: state_d = state_q;
    endcase
  end

  // Next values of the registered outputs and datapath
  always_comb begin
    hold_cnt_d    = hold_cnt_q;
    idx_d         = idx_q;
    last_loaded_d = last_loaded_q;
    core_rst_d    = core_rst_o;
    mem_sel_d     = mem_sel_o;
    mem_addr_d    = mem_addr_o;
    dump_valid_d  = dump_valid_o;
    dump_data_d   = dump_data_o;
    dump_index_d  = dump_index_o;
    done_d        = done_o;
    timeout_d     = timeout_o;
    exit_code_d   = exit_code_o;
    cycle_count_d = cycle_count_o;
    case (state_q)
      S_HOLD: begin
        if (hold_done_c) core_rst_d = 1'b0;
        else             hold_cnt_d = hold_cnt_q + HOLD_W'(1);
      end
      S_RUN: begin
        cycle_count_d = cyc_inc_c;
        if (halt_c || timeout_hit_c) begin
          core_rst_d    = 1'b1;
          mem_sel_d     = 1'b1;
          mem_addr_d    = DUMP_BASE;
          idx_d         = 16'd0;
          last_loaded_d = 1'b0;
          // A halt in the final cycle takes precedence over the timeout
          if (halt_c) exit_code_d = data_wdata_i;
          else        timeout_d   = 1'b1;
        end
      end
      S_DUMP: begin
        if (last_hs_c) begin
          dump_valid_d = 1'b0;
          mem_sel_d    = 1'b0;
          done_d       = 1'b1;
        end else if (load_c) begin
          dump_data_d   = mem_rdata_i;
          dump_index_d  = idx_q;
          dump_valid_d  = 1'b1;
          idx_d         = idx_q + 16'd1;
          mem_addr_d    = mem_addr_o + ADDR_W'(4);
          last_loaded_d = (idx_q == LAST_IDX);
        end
      end
      default: ;
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt_q    <= '0;
      idx_q         <= '0;
      last_loaded_q <= 1'b0;
      core_rst_o    <= 1'b1;
      mem_sel_o     <= 1'b0;
      mem_addr_o    <= '0;
      dump_valid_o  <= 1'b0;
      dump_data_o   <= '0;
      dump_index_o  <= '0;
      done_o        <= 1'b0;
      timeout_o     <= 1'b0;
      exit_code_o   <= '0;
      cycle_count_o <= '0;
    end else begin
      hold_cnt_q    <= hold_cnt_d;
      idx_q         <= idx_d;
      last_loaded_q <= last_loaded_d;
      core_rst_o    <= core_rst_d;
      mem_sel_o     <= mem_sel_d;
      mem_addr_o    <= mem_addr_d;
      dump_valid_o  <= dump_valid_d;
      dump_data_o   <= dump_data_d;
      dump_index_o  <= dump_index_d;
      done_o        <= done_d;
      timeout_o     <= timeout_d;
      exit_code_o   <= exit_code_d;
      cycle_count_o <= cycle_count_d;
    end
  end

`ifdef SOC_RUN_CTRL_STORE_COUNT_EN
  // Saturating count of RUN-state stores, halt store included
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      store_count_o <= '0;
    end else if (state_q == S_RUN && data_ce_i && data_we_i &&
                 store_count_o != 32'hFFFF_FFFF) begin
      store_count_o <= store_count_o + 32'd1;
    end
  end
`else
  assign store_count_o = 32'd0;
`endif

endmodule

// File: tb/tb_soc_run_ctrl.sv
// Directed bench for soc_run_ctrl: reset release, halt, timeout, dump with backpressure, mid-dump reset, tie case.
module tb_soc_run_ctrl;

  localparam logic [31:0] HALT = 32'h0000_0FFC;
`ifdef SOC_RUN_CTRL_STORE_COUNT_EN
  localparam logic [31:0] EXP_SC_HALT = 32'd5;
  localparam logic [31:0] EXP_SC_TIE  = 32'd1;
`else
  localparam logic [31:0] EXP_SC_HALT = 32'd0;
  localparam logic [31:0] EXP_SC_TIE  = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        core_rst_o;
  logic        data_ce_i = 1'b0, data_we_i = 1'b0;
  logic [31:0] data_addr_i = '0, data_wdata_i = '0;
  logic        mem_sel_o;
  logic [31:0] mem_addr_o, mem_rdata_i;
  logic        dump_valid_o;
  logic        dump_ready_i = 1'b0;
  logic [31:0] dump_data_o;
  logic [15:0] dump_index_o;
  logic        done_o, timeout_o;
  logic [31:0] exit_code_o, cycle_count_o, store_count_o;

  logic [31:0] mem [4];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  initial begin
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
  end

  always_comb mem_rdata_i = (mem_addr_o < 32'd16) ? mem[mem_addr_o[3:2]] : 32'hDEAD_BEEF;

  soc_run_ctrl #(.MAX_CYCLES(100), .DUMP_WORDS(4)) dut (
    .clk(clk), .rst(rst), .core_rst_o(core_rst_o),
    .data_ce_i(data_ce_i), .data_we_i(data_we_i), .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .mem_sel_o(mem_sel_o), .mem_addr_o(mem_addr_o), .mem_rdata_i(mem_rdata_i),
    .dump_valid_o(dump_valid_o), .dump_ready_i(dump_ready_i), .dump_data_o(dump_data_o), .dump_index_o(dump_index_o),
    .done_o(done_o), .timeout_o(timeout_o), .exit_code_o(exit_code_o),
    .cycle_count_o(cycle_count_o), .store_count_o(store_count_o)
  );

  task automatic set_bus(input logic ce, input logic we, input logic [31:0] addr, input logic [31:0] wd);
    data_ce_i = ce; data_we_i = we; data_addr_i = addr; data_wdata_i = wd;
  endtask

  // Pulse reset, release it, and land in the first RUN cycle
  task automatic release_rst();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (core_rst_o !== 1'b1) begin failures++; $display("FAIL reset_core_rst: got %b expected 1", core_rst_o); end
    checks++; if (mem_sel_o !== 1'b0 || dump_valid_o !== 1'b0 || done_o !== 1'b0 || timeout_o !== 1'b0) begin
      failures++; $display("FAIL reset_flags: sel=%b valid=%b done=%b timeout=%b expected all 0", mem_sel_o, dump_valid_o, done_o, timeout_o); end
    checks++; if (exit_code_o !== 32'd0 || cycle_count_o !== 32'd0 || store_count_o !== 32'd0 || mem_addr_o !== 32'd0) begin
      failures++; $display("FAIL reset_values: exit=%h cyc=%h st=%h addr=%h expected 0", exit_code_o, cycle_count_o, store_count_o, mem_addr_o); end
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      checks++; if (core_rst_o !== ((i < 3) ? 1'b1 : 1'b0)) begin
        failures++; $display("FAIL release_edge%0d: got %b expected %b", i, core_rst_o, (i < 3) ? 1'b1 : 1'b0); end
    end
    checks++; if (cycle_count_o !== 32'd0) begin failures++; $display("FAIL run_start_count: got %0d expected 0", cycle_count_o); end
  endtask

  // Halt store issued in the 57th RUN cycle, after four ordinary stores and two non-halting HALT_ADDR accesses
  task automatic test_halt();
    for (int c = 1; c <= 57; c++) begin
      if (c >= 10 && c <= 13) set_bus(1'b1, 1'b1, 32'h100, 32'(c));
      else if (c == 20)       set_bus(1'b1, 1'b0, HALT, 32'h77);
      else if (c == 21)       set_bus(1'b0, 1'b1, HALT, 32'h77);
      else if (c == 57)       set_bus(1'b1, 1'b1, HALT, 32'h2A);
      else                    set_bus(1'b0, 1'b0, 32'h0, 32'h0);
      if (c == 57) begin
        checks++; if (cycle_count_o !== 32'd56 || core_rst_o !== 1'b0) begin
          failures++; $display("FAIL pre_halt: cyc=%0d core_rst=%b expected 56/0", cycle_count_o, core_rst_o); end
      end
      @(negedge clk);
    end
    set_bus(1'b0, 1'b0, 32'h0, 32'h0);
    checks++; if (exit_code_o !== 32'h2A) begin failures++; $display("FAIL halt_exit: got %h expected 2a", exit_code_o); end
    checks++; if (core_rst_o !== 1'b1 || timeout_o !== 1'b0) begin
      failures++; $display("FAIL halt_flags: core_rst=%b timeout=%b expected 1/0", core_rst_o, timeout_o); end
    checks++; if (cycle_count_o !== 32'd57) begin failures++; $display("FAIL halt_count: got %0d expected 57", cycle_count_o); end
    checks++; if (mem_sel_o !== 1'b1 || dump_valid_o !== 1'b0 || mem_addr_o !== 32'd0) begin
      failures++; $display("FAIL dump_entry: sel=%b valid=%b addr=%h expected 1/0/0", mem_sel_o, dump_valid_o, mem_addr_o); end
    checks++; if (store_count_o !== EXP_SC_HALT) begin failures++; $display("FAIL store_count: got %0d expected %0d", store_count_o, EXP_SC_HALT); end
  endtask

  task automatic test_dump_backpressure();
    logic        pat [4];
    int          exp_idx, k;
    logic        prev_stall;
    logic [31:0] prev_data;
    logic [15:0] prev_index;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    exp_idx = 0; k = 0; prev_stall = 1'b0; prev_data = '0; prev_index = '0;
    for (int cyc = 0; cyc < 40 && done_o !== 1'b1; cyc++) begin
      if (cyc < 2) begin
        checks++; if (dump_valid_o !== ((cyc == 1) ? 1'b1 : 1'b0)) begin
          failures++; $display("FAIL valid_latency_c%0d: got %b expected %b", cyc, dump_valid_o, (cyc == 1) ? 1'b1 : 1'b0); end
      end
      if (dump_valid_o === 1'b1) begin
        checks++; if (exp_idx > 3 || dump_data_o !== mem[exp_idx[1:0]] || dump_index_o !== 16'(exp_idx)) begin
          failures++; $display("FAIL bp_word: data=%h idx=%0d expected word %0d", dump_data_o, dump_index_o, exp_idx); end
        if (prev_stall) begin
          checks++; if (dump_data_o !== prev_data || dump_index_o !== prev_index) begin
            failures++; $display("FAIL bp_stable: data=%h idx=%0d expected %h/%0d", dump_data_o, dump_index_o, prev_data, prev_index); end
        end
      end
      dump_ready_i = pat[k % 4];
      k++;
      prev_stall = (dump_valid_o === 1'b1) && !dump_ready_i;
      prev_data  = dump_data_o;
      prev_index = dump_index_o;
      if (dump_valid_o === 1'b1 && dump_ready_i) exp_idx++;
      @(negedge clk);
    end
    dump_ready_i = 1'b0;
    checks++; if (done_o !== 1'b1 || exp_idx != 4) begin
      failures++; $display("FAIL bp_done: done=%b handshakes=%0d expected 1/4", done_o, exp_idx); end
    checks++; if (dump_valid_o !== 1'b0 || mem_sel_o !== 1'b0 || core_rst_o !== 1'b1) begin
      failures++; $display("FAIL done_outputs: valid=%b sel=%b core_rst=%b expected 0/0/1", dump_valid_o, mem_sel_o, core_rst_o); end
  endtask

  task automatic test_done_terminal();
    for (int i = 0; i < 5; i++) begin
      set_bus(1'b1, 1'b1, HALT, 32'h99);
      dump_ready_i = 1'b1;
      @(negedge clk);
    end
    set_bus(1'b0, 1'b0, 32'h0, 32'h0);
    dump_ready_i = 1'b0;
    checks++; if (done_o !== 1'b1 || exit_code_o !== 32'h2A || cycle_count_o !== 32'd57 || dump_valid_o !== 1'b0) begin
      failures++; $display("FAIL done_terminal: done=%b exit=%h cyc=%0d valid=%b expected 1/2a/57/0", done_o, exit_code_o, cycle_count_o, dump_valid_o); end
    checks++; if (store_count_o !== EXP_SC_HALT) begin failures++; $display("FAIL done_store_hold: got %0d expected %0d", store_count_o, EXP_SC_HALT); end
  endtask

  task automatic test_timeout();
    release_rst();
    for (int c = 1; c <= 100; c++) begin
      if (c == 30)      set_bus(1'b1, 1'b0, HALT, 32'h55);
      else if (c == 31) set_bus(1'b0, 1'b1, HALT, 32'h55);
      else              set_bus(1'b0, 1'b0, 32'h0, 32'h0);
      if (c == 100) begin
        checks++; if (core_rst_o !== 1'b0 || timeout_o !== 1'b0) begin
          failures++; $display("FAIL pre_timeout: core_rst=%b timeout=%b expected 0/0", core_rst_o, timeout_o); end
      end
      @(negedge clk);
    end
    set_bus(1'b0, 1'b0, 32'h0, 32'h0);
    checks++; if (timeout_o !== 1'b1 || exit_code_o !== 32'd0) begin
      failures++; $display("FAIL timeout_flags: timeout=%b exit=%h expected 1/0", timeout_o, exit_code_o); end
    checks++; if (cycle_count_o !== 32'd100 || core_rst_o !== 1'b1 || mem_sel_o !== 1'b1) begin
      failures++; $display("FAIL timeout_state: cyc=%0d core_rst=%b sel=%b expected 100/1/1", cycle_count_o, core_rst_o, mem_sel_o); end
  endtask

  task automatic test_mid_dump_reset();
    logic hit;
    hit = 1'b0;
    dump_ready_i = 1'b1;
    for (int cyc = 0; cyc < 10 && !hit; cyc++) begin
      if (dump_valid_o === 1'b1 && dump_index_o === 16'd2) begin
        hit = 1'b1;
        checks++; if (dump_data_o !== 32'h33) begin failures++; $display("FAIL mid_word2: got %h expected 33", dump_data_o); end
        rst = 1'b1;
        #1;
        checks++; if (core_rst_o !== 1'b1 || dump_valid_o !== 1'b0 || mem_sel_o !== 1'b0 || done_o !== 1'b0 || timeout_o !== 1'b0) begin
          failures++; $display("FAIL mid_reset_flags: core_rst=%b valid=%b sel=%b done=%b timeout=%b expected 1/0/0/0/0",
                               core_rst_o, dump_valid_o, mem_sel_o, done_o, timeout_o); end
        checks++; if (cycle_count_o !== 32'd0 || dump_index_o !== 16'd0 || dump_data_o !== 32'd0 || mem_addr_o !== 32'd0 || exit_code_o !== 32'd0) begin
          failures++; $display("FAIL mid_reset_values: cyc=%0d idx=%0d data=%h addr=%h exit=%h expected 0",
                               cycle_count_o, dump_index_o, dump_data_o, mem_addr_o, exit_code_o); end
      end else begin
        @(negedge clk);
      end
    end
    dump_ready_i = 1'b0;
    checks++; if (!hit) begin failures++; $display("FAIL mid_reset_reach: got no word 2 expected word 2 within 10 cycles"); end
  endtask

  // Rerun: halt store coincides with the timeout cycle, then a full-rate dump
  task automatic test_back_to_back();
    @(negedge clk);
    release_rst();
    for (int c = 1; c <= 100; c++) begin
      if (c == 100) set_bus(1'b1, 1'b1, HALT, 32'h5A5A);
      else          set_bus(1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
    end
    set_bus(1'b0, 1'b0, 32'h0, 32'h0);
    checks++; if (timeout_o !== 1'b0 || exit_code_o !== 32'h5A5A || cycle_count_o !== 32'd100) begin
      failures++; $display("FAIL tie_halt_wins: timeout=%b exit=%h cyc=%0d expected 0/5a5a/100", timeout_o, exit_code_o, cycle_count_o); end
    checks++; if (store_count_o !== EXP_SC_TIE) begin failures++; $display("FAIL tie_store_count: got %0d expected %0d", store_count_o, EXP_SC_TIE); end
    dump_ready_i = 1'b1;
    for (int cyc = 0; cyc <= 5; cyc++) begin
      if (cyc == 0) begin
        checks++; if (dump_valid_o !== 1'b0) begin failures++; $display("FAIL stream_c0: valid=%b expected 0", dump_valid_o); end
      end else if (cyc <= 4) begin
        checks++; if (dump_valid_o !== 1'b1 || dump_index_o !== 16'(cyc - 1) || dump_data_o !== mem[cyc - 1]) begin
          failures++; $display("FAIL stream_word%0d: valid=%b idx=%0d data=%h expected 1/%0d/%h",
                               cyc - 1, dump_valid_o, dump_index_o, dump_data_o, cyc - 1, mem[cyc - 1]); end
      end else begin
        checks++; if (done_o !== 1'b1 || dump_valid_o !== 1'b0 || mem_sel_o !== 1'b0) begin
          failures++; $display("FAIL stream_done: done=%b valid=%b sel=%b expected 1/0/0", done_o, dump_valid_o, mem_sel_o); end
      end
      if (cyc < 5) @(negedge clk);
    end
    dump_ready_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_halt();
    test_dump_backpressure();
    test_done_terminal();
    test_timeout();
    test_mid_dump_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
